pc_unit: RTL and testbench

//  Parametrised program-counter unit; successor to the bare PC register of the single-cycle core.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_if.sv | 29 ++
 rtl/pc_reg.sv | 25 ++
 rtl/pc_unit.sv | 114 +++++++++++
 tb/tb_pc_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM encoding, alignment and default vectors.
package pc_pkg;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    typedef enum logic [1:0] {
        ST_BOOT = S_BOOT,
        ST_RUN  = S_RUN,
        ST_HALT = S_HALT
    } state_t;

    // Instructions are 4-byte aligned; targets with non-zero low bits trap.
    localparam int IALIGN_BITS = 2;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_if.sv
// Control/status bundle between execute/CSR logic (master) and the PC unit (slave).
interface pc_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_req;
    logic            mret;
    logic            halt_req;
    logic            resume;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_valid;
    logic [XLEN-1:0] epc;
    logic            misaligned;
    logic            halted;

    modport master (
        output stall, redirect_valid, redirect_target, trap_req, mret, halt_req, resume,
        input  pc, pc_plus4, fetch_valid, epc, misaligned, halted
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap_req, mret, halt_req, resume,
        output pc, pc_plus4, fetch_valid, epc, misaligned, halted
    );
endinterface

// File: rtl/pc_reg.sv
// XLEN-wide register with synchronous reset to a fixed value and a load enable.
module pc_reg #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_d,
    output logic [XLEN-1:0] o_q
);

    logic [XLEN-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch PC with BOOT/RUN/HALT control, trap/mret/redirect selection and misaligned-target trapping.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
    input  logic clk,
    input  logic rst,
    pc_if.slave  bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_pc_en;
    logic [XLEN-1:0] r_epc;
    logic            w_epc_en;
    logic            r_misaligned;
    logic            w_mis_nxt;
    logic            w_fetch_vld;
    logic            w_halted;
    logic            w_bad_target;
    logic            w_trap;

    pc_reg #(
        .XLEN        (XLEN),
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pc_en),
        .i_d  (w_pc_nxt),
        .o_q  (w_pc)
    );

    assign w_pc_plus4   = w_pc + XLEN'(32'd4);
    assign w_bad_target = bus.redirect_valid && (bus.redirect_target[IALIGN_BITS-1:0] != '0);
    assign w_trap       = bus.trap_req || w_bad_target;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = w_pc;
        w_pc_en     = 1'b0;
        w_epc_en    = 1'b0;
        w_mis_nxt   = 1'b0;
        w_fetch_vld = 1'b0;
        w_halted    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_fetch_vld = !bus.stall;
                if (bus.halt_req) begin
                    w_state_nxt = ST_HALT;
                end
                // Control transfers beat stall and halt; only the sequential step is suppressed.
                if (w_trap) begin
                    w_pc_nxt  = TRAP_VECTOR;
                    w_pc_en   = 1'b1;
                    w_epc_en  = 1'b1;
                    w_mis_nxt = w_bad_target;
                end else if (bus.mret) begin
                    w_pc_nxt = r_epc;
                    w_pc_en  = 1'b1;
                end else if (bus.redirect_valid) begin
                    w_pc_nxt = bus.redirect_target;
                    w_pc_en  = 1'b1;
                end else if (!bus.stall && !bus.halt_req) begin
                    w_pc_nxt = w_pc_plus4;
                    w_pc_en  = 1'b1;
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
                // The halting instruction was already fetched, so resume steps past it.
                if (bus.resume) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_pc_plus4;
                    w_pc_en     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_epc        <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_misaligned <= w_mis_nxt;
            if (w_epc_en) begin
                r_epc <= w_pc;
            end
        end
    end

    assign bus.pc          = w_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.epc         = r_epc;
    assign bus.misaligned  = r_misaligned;
    assign bus.fetch_valid = w_fetch_vld && !rst;
    assign bus.halted      = w_halted && !rst;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit (XLEN=32 and XLEN=8) with a cycle-level reference model.
module tb_pc_unit;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        bit          mis;
        int          mode;
    } mstate_t;

    logic clk = 1'b0;
    logic rst32;
    logic rst8;
    int   n_checks = 0;
    int   n_fail   = 0;

    mstate_t m32, m8;
    bit      k32 = 1'b0;
    bit      k8  = 1'b0;

    always #5 clk = ~clk;

    pc_if #(.XLEN(32)) bus32 ();
    pc_if #(.XLEN(8))  bus8 ();

    pc_unit #(.XLEN(32)) u_dut32 (
        .clk (clk),
        .rst (rst32),
        .bus (bus32.slave)
    );

    pc_unit #(.XLEN(8), .RESET_VECTOR(8'h10), .TRAP_VECTOR(8'h80)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int xlen);
        return (xlen >= 32) ? 32'hFFFF_FFFF : ((32'd1 << xlen) - 32'd1);
    endfunction

    // Next architectural state from the current one and the inputs sampled at the edge.
    function automatic mstate_t mstep(input mstate_t s, input bit rst, input bit stall,
                                      input bit rv, input logic [31:0] tgt, input bit trap,
                                      input bit mret, input bit hreq, input bit res,
                                      input int xlen, input logic [31:0] rvec,
                                      input logic [31:0] tvec);
        mstate_t     n;
        logic [31:0] m;
        bit          bad;
        m     = wmask(xlen);
        n     = s;
        n.mis = 1'b0;
        bad   = rv && ((tgt % 4) != 0);
        if (rst) begin
            n.pc   = rvec;
            n.epc  = 32'h0;
            n.mode = M_BOOT;
        end else if (s.mode == M_BOOT) begin
            n.mode = M_RUN;
        end else if (s.mode == M_HALT) begin
            if (res) begin
                n.mode = M_RUN;
                n.pc   = (s.pc + 4) & m;
            end
        end else begin
            if (trap || bad) begin
                n.epc = s.pc;
                n.pc  = tvec;
                n.mis = bad;
            end else if (mret) begin
                n.pc = s.epc;
            end else if (rv) begin
                n.pc = tgt & m;
            end else if (!stall && !hreq) begin
                n.pc = (s.pc + 4) & m;
            end
            if (hreq) n.mode = M_HALT;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m32 <= mstep(m32, rst32, bus32.stall, bus32.redirect_valid, bus32.redirect_target,
                     bus32.trap_req, bus32.mret, bus32.halt_req, bus32.resume,
                     32, 32'h0, 32'h100);
        m8  <= mstep(m8, rst8, bus8.stall, bus8.redirect_valid, 32'(bus8.redirect_target),
                     bus8.trap_req, bus8.mret, bus8.halt_req, bus8.resume,
                     8, 32'h10, 32'h80);
        if (rst32) k32 <= 1'b1;
        if (rst8)  k8  <= 1'b1;
    end

    always @(negedge clk) begin
        if (k32) begin
            chk("m32.pc",          bus32.pc,                 m32.pc);
            chk("m32.pc_plus4",    bus32.pc_plus4,           m32.pc + 32'd4);
            chk("m32.epc",         bus32.epc,                m32.epc);
            chk("m32.misaligned",  32'(bus32.misaligned),    32'(m32.mis));
            chk("m32.fetch_valid", 32'(bus32.fetch_valid),
                32'(!rst32 && m32.mode == M_RUN && !bus32.stall));
            chk("m32.halted",      32'(bus32.halted),        32'(!rst32 && m32.mode == M_HALT));
        end
        if (k8) begin
            chk("m8.pc",          32'(bus8.pc),          m8.pc);
            chk("m8.pc_plus4",    32'(bus8.pc_plus4),    (m8.pc + 32'd4) & wmask(8));
            chk("m8.epc",         32'(bus8.epc),         m8.epc);
            chk("m8.misaligned",  32'(bus8.misaligned),  32'(m8.mis));
            chk("m8.fetch_valid", 32'(bus8.fetch_valid),
                32'(!rst8 && m8.mode == M_RUN && !bus8.stall));
            chk("m8.halted",      32'(bus8.halted),      32'(!rst8 && m8.mode == M_HALT));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr32();
        bus32.stall = 0; bus32.redirect_valid = 0; bus32.redirect_target = '0;
        bus32.trap_req = 0; bus32.mret = 0; bus32.halt_req = 0; bus32.resume = 0;
    endtask

    task automatic clr8();
        bus8.stall = 0; bus8.redirect_valid = 0; bus8.redirect_target = '0;
        bus8.trap_req = 0; bus8.mret = 0; bus8.halt_req = 0; bus8.resume = 0;
    endtask

    task automatic jump32(input logic [31:0] t);
        bus32.redirect_valid = 1; bus32.redirect_target = t;
        step();
        clr32();
        #1;
    endtask

    initial begin
        rst32 = 1; rst8 = 1;
        clr32(); clr8();

        // Reset, BOOT, then sequential fetch.
        step(); step();
        chk("rst.pc", bus32.pc, 32'h0);
        chk("rst.fv", 32'(bus32.fetch_valid), 32'h0);
        rst32 = 0; #1;
        chk("boot.fv", 32'(bus32.fetch_valid), 32'h0);
        step();
        chk("run.pc0", bus32.pc, 32'h0);
        chk("run.fv", 32'(bus32.fetch_valid), 32'h1);
        step(); chk("seq.pc4", bus32.pc, 32'h4);
        step(); chk("seq.pc8", bus32.pc, 32'h8);

        // Stall holds; redirect overrides stall.
        bus32.stall = 1; #1;
        chk("stall.fv", 32'(bus32.fetch_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall.pc", bus32.pc, 32'h8);
        end
        bus32.stall = 0;
        step(); chk("unstall.pc", bus32.pc, 32'hC);
        bus32.stall = 1; bus32.redirect_valid = 1; bus32.redirect_target = 32'h40;
        step(); chk("stall_redir.pc", bus32.pc, 32'h40);
        clr32();

        // Misaligned redirect traps, then mret returns.
        jump32(32'h10);
        bus32.redirect_valid = 1; bus32.redirect_target = 32'h42;
        step();
        chk("mis.pc", bus32.pc, 32'h100);
        chk("mis.epc", bus32.epc, 32'h10);
        chk("mis.pulse", 32'(bus32.misaligned), 32'h1);
        clr32();
        step();
        chk("mis.clear", 32'(bus32.misaligned), 32'h0);
        chk("mis.pc104", bus32.pc, 32'h104);
        bus32.mret = 1;
        step(); chk("mret.pc", bus32.pc, 32'h10);
        clr32();

        // Trap beats an aligned redirect.
        jump32(32'h20);
        bus32.trap_req = 1; bus32.redirect_valid = 1; bus32.redirect_target = 32'h80;
        step();
        chk("trap.pc", bus32.pc, 32'h100);
        chk("trap.epc", bus32.epc, 32'h20);
        chk("trap.mis", 32'(bus32.misaligned), 32'h0);
        clr32();

        // Halt ignores everything but resume.
        jump32(32'h30);
        bus32.halt_req = 1;
        step();
        chk("halt.halted", 32'(bus32.halted), 32'h1);
        chk("halt.pc", bus32.pc, 32'h30);
        clr32();
        bus32.redirect_valid = 1; bus32.redirect_target = 32'h60; bus32.trap_req = 1; bus32.mret = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt.hold_pc", bus32.pc, 32'h30);
            chk("halt.fv", 32'(bus32.fetch_valid), 32'h0);
        end
        clr32();
        bus32.resume = 1;
        step();
        chk("resume.pc", bus32.pc, 32'h34);
        chk("resume.halted", 32'(bus32.halted), 32'h0);
        clr32();
        step(); chk("resume.seq", bus32.pc, 32'h38);

        // Trap and halt together: trap first, halt at the trap vector.
        bus32.trap_req = 1; bus32.halt_req = 1;
        step();
        chk("traphalt.pc", bus32.pc, 32'h100);
        chk("traphalt.epc", bus32.epc, 32'h38);
        chk("traphalt.halted", 32'(bus32.halted), 32'h1);
        clr32();

        // Reset while running with a redirect pending.
        step();
        bus32.resume = 1;
        step();
        bus32.resume = 0; bus32.redirect_valid = 1; bus32.redirect_target = 32'h200;
        rst32 = 1;
        step();
        chk("midrst.pc", bus32.pc, 32'h0);
        chk("midrst.epc", bus32.epc, 32'h0);
        rst32 = 0; clr32();

        // XLEN=8: wrap, misaligned trap, reset mid-HALT.
        rst8 = 0; #1;
        chk("x8.boot.pc", 32'(bus8.pc), 32'h10);
        step();
        bus8.redirect_valid = 1; bus8.redirect_target = 8'hF8;
        step(); chk("x8.pcF8", 32'(bus8.pc), 32'hF8);
        clr8();
        step(); chk("x8.pcFC", 32'(bus8.pc), 32'hFC);
        chk("x8.plus4_wrap", 32'(bus8.pc_plus4), 32'h00);
        step(); chk("x8.pc00", 32'(bus8.pc), 32'h00);
        bus8.redirect_valid = 1; bus8.redirect_target = 8'h13;
        step();
        chk("x8.mis.pc", 32'(bus8.pc), 32'h80);
        chk("x8.mis.pulse", 32'(bus8.misaligned), 32'h1);
        clr8();
        bus8.halt_req = 1;
        step(); chk("x8.halted", 32'(bus8.halted), 32'h1);
        clr8();
        step();
        rst8 = 1;
        step();
        chk("x8.rst.pc", 32'(bus8.pc), 32'h10);
        chk("x8.rst.halted", 32'(bus8.halted), 32'h0);
        rst8 = 0; #1;
        chk("x8.rst.boot_fv", 32'(bus8.fetch_valid), 32'h0);
        step(); chk("x8.rst.run_fv", 32'(bus8.fetch_valid), 32'h1);
        step(); chk("x8.rst.seq", 32'(bus8.pc), 32'h14);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
